timers_intc: RTL and testbench

TIMERS_INTC -- requirements
Module: timers_intc

---
 rtl/timers_intc.sv | 84 ++++++++
 tb/tb_timers_intc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/timers_intc.sv
// rtl/timers_intc.sv - timer interrupt controller with sticky pending flags and optional overrun counters
// Optional feature: define TIMERS_INTC_OVR_CNT_EN to build the per-channel overrun counters.
module timers_intc #(
   parameter int TIMER_NUM = 4,
   parameter int OVR_WIDTH = 4
) (
   input  logic                           timer_clk,
   input  logic                           timer_rst,
   input  logic [TIMER_NUM-1:0]           timer_interrupt,
   input  logic [TIMER_NUM-1:0]           timer_en,
   input  logic [TIMER_NUM-1:0]           int_mask,
   input  logic [TIMER_NUM-1:0]           eoi,
   input  logic                           eoi_all,
   output logic [TIMER_NUM-1:0]           raw_status,
   output logic [TIMER_NUM-1:0]           int_status,
   output logic                           intr_out,
   output logic [TIMER_NUM*OVR_WIDTH-1:0] ovr_count
);

   logic [TIMER_NUM-1:0] int_d;
   logic [TIMER_NUM-1:0] evt;
   logic [TIMER_NUM-1:0] clr;
   logic                 armed;

   // armed stays low for the first clock after reset so a pulse already high at release is absorbed into int_d
   assign evt = timer_interrupt & ~int_d & timer_en & {TIMER_NUM{armed}};
   assign clr = eoi | {TIMER_NUM{eoi_all}};

   always_ff @(posedge timer_clk or posedge timer_rst) begin
      if (timer_rst) begin
         armed      <= 1'b0;
         int_d      <= '0;
         raw_status <= '0;
      end else begin
         armed <= 1'b1;
         for (int k = 0; k < TIMER_NUM; k++) begin
            if (!timer_en[k]) begin
               int_d[k]      <= 1'b0;
               raw_status[k] <= 1'b0;
            end else begin
               int_d[k] <= timer_interrupt[k];
               if (evt[k])
                  raw_status[k] <= 1'b1;
               else if (clr[k])
                  raw_status[k] <= 1'b0;
            end
         end
      end
   end

`ifdef TIMERS_INTC_OVR_CNT_EN
   logic [OVR_WIDTH-1:0] ovr [TIMER_NUM];

   // a set coinciding with a clear starts a fresh pending period, so the count restarts at 0
   always_ff @(posedge timer_clk or posedge timer_rst) begin
      if (timer_rst) begin
         for (int k = 0; k < TIMER_NUM; k++)
            ovr[k] <= '0;
      end else begin
         for (int k = 0; k < TIMER_NUM; k++) begin
            if (!timer_en[k])
               ovr[k] <= '0;
            else if (evt[k]) begin
               if (clr[k])
                  ovr[k] <= '0;
               else if (raw_status[k] && (ovr[k] != {OVR_WIDTH{1'b1}}))
                  ovr[k] <= ovr[k] + 1'b1;
            end else if (clr[k])
               ovr[k] <= '0;
         end
      end
   end

   for (genvar g = 0; g < TIMER_NUM; g++) begin : g_pack
      assign ovr_count[g*OVR_WIDTH +: OVR_WIDTH] = ovr[g];
   end
`else
   assign ovr_count = '0;
`endif

   assign int_status = raw_status & ~int_mask;
   assign intr_out   = |int_status;

endmodule

// File: tb/tb_timers_intc.sv
// tb/tb_timers_intc.sv - directed self-checking bench for timers_intc
// Overrun expectations follow TIMERS_INTC_OVR_CNT_EN (counters expected at 0 when undefined).
module tb_timers_intc;

`ifdef TIMERS_INTC_OVR_CNT_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  ti = '0;
   logic [3:0]  en = 4'hF;
   logic [3:0]  mask = '0;
   logic [3:0]  eoi = '0;
   logic        eoi_all = 1'b0;
   logic [3:0]  raw_status;
   logic [3:0]  int_status;
   logic        intr_out;
   logic [15:0] ovr_count;

   int n_assert = 0;
   int n_fail = 0;
   int exp_ovr;

   timers_intc #(.TIMER_NUM(4), .OVR_WIDTH(4)) dut (
      .timer_clk(clk),
      .timer_rst(rst),
      .timer_interrupt(ti),
      .timer_en(en),
      .int_mask(mask),
      .eoi(eoi),
      .eoi_all(eoi_all),
      .raw_status(raw_status),
      .int_status(int_status),
      .intr_out(intr_out),
      .ovr_count(ovr_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      #2;
      chk("reset_raw", raw_status, 4'h0);
      chk("reset_intr", intr_out, 1'b0);
      chk("reset_ovr", ovr_count, 16'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();

      // ch0: 4-cycle pulse, single event
      ti[0] = 1'b1;
      tick();
      chk("p4_raw_rise", raw_status, 4'b0001);
      chk("p4_intr_rise", intr_out, 1'b1);
      chk("p4_ovr_rise", ovr_count[3:0], 4'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("p4_raw_hold", raw_status, 4'b0001);
         chk("p4_ovr_hold", ovr_count[3:0], 4'h0);
      end
      ti[0] = 1'b0;
      tick();
      chk("p4_raw_wait", raw_status, 4'b0001);
      eoi[0] = 1'b1;
      tick();
      eoi[0] = 1'b0;
      chk("p4_raw_eoi", raw_status, 4'b0000);
      chk("p4_intr_eoi", intr_out, 1'b0);

      // ch1: 20 single-cycle pulses, saturating overrun
      for (int i = 0; i < 20; i++) begin
         ti[1] = 1'b1;
         tick();
         ti[1] = 1'b0;
         tick();
         exp_ovr = OVR_EN ? ((i > 15) ? 15 : i) : 0;
         chk("sat_ovr1", ovr_count[7:4], exp_ovr[3:0]);
      end
      chk("sat_raw", raw_status, 4'b0010);
      eoi_all = 1'b1;
      tick();
      eoi_all = 1'b0;
      chk("sat_clr_ovr", ovr_count, 16'h0);
      chk("sat_clr_raw", raw_status, 4'b0000);

      // ch2: set wins over same-cycle eoi
      for (int i = 0; i < 4; i++) begin
         ti[2] = 1'b1;
         tick();
         ti[2] = 1'b0;
         tick();
      end
      exp_ovr = OVR_EN ? 3 : 0;
      chk("sw_ovr_pre", ovr_count[11:8], exp_ovr[3:0]);
      ti[2] = 1'b1;
      eoi[2] = 1'b1;
      tick();
      eoi[2] = 1'b0;
      ti[2] = 1'b0;
      chk("sw_raw", raw_status, 4'b0100);
      chk("sw_ovr", ovr_count[11:8], 4'h0);
      eoi[2] = 1'b1;
      tick();
      eoi[2] = 1'b0;
      chk("sw_clr", raw_status, 4'b0000);

      // eoi on idle channel has no effect
      eoi[1] = 1'b1;
      tick();
      eoi[1] = 1'b0;
      chk("idle_eoi", raw_status, 4'b0000);

      // ch3 masked, then unmasked combinationally
      mask[3] = 1'b1;
      ti[3] = 1'b1;
      tick();
      ti[3] = 1'b0;
      chk("mask_raw", raw_status, 4'b1000);
      chk("mask_int", int_status, 4'b0000);
      chk("mask_intr", intr_out, 1'b0);
      mask[3] = 1'b0;
      #1;
      chk("unmask_int", int_status, 4'b1000);
      chk("unmask_intr", intr_out, 1'b1);
      chk("unmask_raw", raw_status, 4'b1000);
      eoi[3] = 1'b1;
      tick();
      eoi[3] = 1'b0;

      // simultaneous events on several channels
      ti = 4'b0111;
      tick();
      ti = 4'b0000;
      chk("multi_raw", raw_status, 4'b0111);
      eoi_all = 1'b1;
      tick();
      eoi_all = 1'b0;
      chk("multi_clr", raw_status, 4'b0000);

      // async reset while pending, pulse held through release
      ti[0] = 1'b1;
      tick();
      chk("ar_pend", raw_status, 4'b0001);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_raw", raw_status, 4'b0000);
      chk("ar_intr", intr_out, 1'b0);
      chk("ar_ovr", ovr_count, 16'h0);
      tick();
      #2;
      rst = 1'b0;
      tick();
      tick();
      chk("ar_noreplay", raw_status, 4'b0000);
      ti[0] = 1'b0;
      tick();

      // disable clears pending and ignores pulses
      ti[0] = 1'b1;
      tick();
      ti[0] = 1'b0;
      chk("dis_pend", raw_status, 4'b0001);
      en[0] = 1'b0;
      tick();
      chk("dis_clr", raw_status, 4'b0000);
      ti[0] = 1'b1;
      tick();
      ti[0] = 1'b0;
      tick();
      chk("dis_ignore", raw_status, 4'b0000);
      ti[0] = 1'b1;
      tick();
      en[0] = 1'b1;
      tick();
      chk("reen_event", raw_status, 4'b0001);
      tick();
      ti[0] = 1'b0;
      chk("reen_ovr", ovr_count[3:0], 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
